// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: shifts a WIDTH-bit word out MSB first,
// holding each bit DIV cycles and strobing o_ser_en on the last cycle of each bit.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a word; o_load_ready high unless reset is asserted
// S_SHIFT | frame in flight; o_ser_d is the shift register MSB
module piso_tx #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data_in,
    input  logic             i_load_valid,
    output logic             o_load_ready,
    output logic             o_ser_d,
    output logic             o_ser_en,
    output logic             o_busy,
    output logic             o_done
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DCNT_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BCNT_FULL = BW'(WIDTH);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_sh, w_sh_nxt;
    logic [BW-1:0]    r_bcnt, w_bcnt_nxt;
    logic [DW-1:0]    r_dcnt, w_dcnt_nxt;
    logic             w_bit_end;
    logic             w_last;

    assign w_bit_end = (r_state == S_SHIFT) && (r_dcnt == DCNT_LAST);
    assign w_last    = w_bit_end && (r_bcnt == BW'(1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_sh    <= '0;
            r_bcnt  <= '0;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sh    <= w_sh_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_dcnt  <= w_dcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh;
        w_bcnt_nxt  = r_bcnt;
        w_dcnt_nxt  = r_dcnt;
        if (r_state == S_IDLE) begin
            if (i_load_valid) begin
                w_sh_nxt    = i_data_in;
                w_bcnt_nxt  = BCNT_FULL;
                w_dcnt_nxt  = '0;
                w_state_nxt = S_SHIFT;
            end
        end else begin
            if (w_bit_end) begin
                // The bit just strobed is retired; zero fill keeps o_ser_d clean afterwards.
                w_dcnt_nxt = '0;
                w_sh_nxt   = {r_sh[WIDTH-2:0], 1'b0};
                w_bcnt_nxt = r_bcnt - BW'(1);
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end else begin
                w_dcnt_nxt = r_dcnt + DW'(1);
            end
        end
    end

    // Reset is the only input allowed to reach an output combinationally.
    assign o_load_ready = (r_state == S_IDLE) && !i_rst;
    assign o_busy       = (r_state == S_SHIFT);
    assign o_ser_d      = (r_state == S_SHIFT) && r_sh[WIDTH-1];
    assign o_ser_en     = w_bit_end;
    assign o_done       = w_last;

endmodule
